// File: rtl/reflet_inst16_arbiter.sv
// Two-port arbiter for the 16-bit instruction memory: CPU fetch path (A) and loader/debug path (B).
// Every access is a registered single-word IDLE -> ACCESS -> DONE transaction, acked in DONE.
module reflet_inst16_arbiter #(
   parameter int unsigned FIXED_PRIO = 32'd0,
   parameter int unsigned ADDR_W     = 32'd15,
   parameter int unsigned DATA_W     = 32'd16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_ready,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   input  logic              a_we,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   input  logic              b_we,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   input  logic              b_lock,
   output logic              mem_enable,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_write_en,
   input  logic [DATA_W-1:0] mem_data_out,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   state_t            state_q, state_d;
   logic              sel_q, sel_d;
   logic              last_q, last_d;
   logic              mem_enable_q, mem_enable_d;
   logic              mem_write_en_q, mem_write_en_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
   logic              a_ack_q, a_ack_d;
   logic              b_ack_q, b_ack_d;
   logic              busy_q, busy_d;

   logic a_elig_s;
   logic b_elig_s;
   logic tie_b_s;
   logic grant_s;
   logic grant_b_s;

   assign a_elig_s = a_req & ~b_lock & mem_ready;
   assign b_elig_s = b_req & mem_ready;
   // On a tie, round-robin picks the port that was not granted last.
   assign tie_b_s  = (FIXED_PRIO != 32'd0) ? PORT_A : ~last_q;

   // Next-state, winner selection and memory-side register loads.
   always_comb begin
      state_d        = state_q;
      sel_d          = sel_q;
      last_d         = last_q;
      mem_enable_d   = 1'b0;
      mem_write_en_d = 1'b0;
      mem_addr_d     = mem_addr_q;
      mem_data_in_d  = mem_data_in_q;
      a_ack_d        = 1'b0;
      b_ack_d        = 1'b0;
      grant_s        = 1'b0;
      grant_b_s      = PORT_A;

      case (state_q)
         ST_IDLE: begin
            if (a_elig_s | b_elig_s) begin
               grant_s   = 1'b1;
               grant_b_s = (a_elig_s & b_elig_s) ? tie_b_s : b_elig_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            state_d = ST_DONE;
            a_ack_d = (sel_q == PORT_A);
            b_ack_d = (sel_q == PORT_B);
         end
         ST_DONE: begin
            // The port acked now still holds req this cycle, so only the other one may win.
            state_d = ST_IDLE;
            if (sel_q == PORT_A) begin
               grant_s   = b_elig_s;
               grant_b_s = PORT_B;
            end else begin
               grant_s   = a_elig_s;
               grant_b_s = PORT_A;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (grant_s) begin
         state_d        = ST_ACCESS;
         sel_d          = grant_b_s;
         last_d         = grant_b_s;
         mem_enable_d   = 1'b1;
         mem_addr_d     = grant_b_s ? b_addr  : a_addr;
         mem_data_in_d  = grant_b_s ? b_wdata : a_wdata;
         mem_write_en_d = grant_b_s ? b_we    : a_we;
      end else begin
         mem_enable_d = 1'b0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset aborts any transaction without an ack.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         sel_q          <= PORT_A;
         last_q         <= PORT_B;
         mem_enable_q   <= 1'b0;
         mem_write_en_q <= 1'b0;
         mem_addr_q     <= {ADDR_W{1'b0}};
         mem_data_in_q  <= {DATA_W{1'b0}};
         a_ack_q        <= 1'b0;
         b_ack_q        <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         sel_q          <= sel_d;
         last_q         <= last_d;
         mem_enable_q   <= mem_enable_d;
         mem_write_en_q <= mem_write_en_d;
         mem_addr_q     <= mem_addr_d;
         mem_data_in_q  <= mem_data_in_d;
         a_ack_q        <= a_ack_d;
         b_ack_q        <= b_ack_d;
         busy_q         <= busy_d;
      end
   end

   // Read data only becomes valid in DONE, so it is gated by the registered ack.
   assign a_rdata      = a_ack_q ? mem_data_out : {DATA_W{1'b0}};
   assign b_rdata      = b_ack_q ? mem_data_out : {DATA_W{1'b0}};
   assign a_ack        = a_ack_q;
   assign b_ack        = b_ack_q;
   assign mem_enable   = mem_enable_q;
   assign mem_write_en = mem_write_en_q;
   assign mem_addr     = mem_addr_q;
   assign mem_data_in  = mem_data_in_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_reflet_inst16_arbiter.sv
// Bench for reflet_inst16_arbiter: memory model, ack scoreboard and one task per scenario.
// A second instance with FIXED_PRIO=1 shares the inputs for the priority scenario.
module tb_reflet_inst16_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_ready;
   logic        a_req, a_we, b_req, b_we, b_lock;
   logic [14:0] a_addr, b_addr;
   logic [15:0] a_wdata, b_wdata;
   logic        a_ack, b_ack, mem_enable, mem_write_en, busy;
   logic [15:0] a_rdata, b_rdata, mem_data_in, mem_data_out;
   logic [14:0] mem_addr;
   logic        f_a_ack, f_b_ack, f_mem_enable, f_mem_write_en, f_busy;
   logic [15:0] f_a_rdata, f_b_rdata, f_mem_data_in;
   logic [14:0] f_mem_addr;
   logic [15:0] f_mem_data_out = 16'h0000;

   typedef struct {
      logic        port;
      logic        chk;
      logic [15:0] data;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   bit   mon_en = 1'b1;

   logic [15:0] mem [0:32767];
   bit          wrt [0:32767];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   reflet_inst16_arbiter #(.FIXED_PRIO(0), .ADDR_W(15), .DATA_W(16)) dut (
      .clk(clk), .reset(reset), .mem_ready(mem_ready),
      .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_we(a_we), .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_we(b_we), .b_ack(b_ack), .b_rdata(b_rdata),
      .b_lock(b_lock), .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_write_en(mem_write_en), .mem_data_out(mem_data_out), .busy(busy));

   reflet_inst16_arbiter #(.FIXED_PRIO(1), .ADDR_W(15), .DATA_W(16)) dut_fp (
      .clk(clk), .reset(reset), .mem_ready(mem_ready),
      .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_we(a_we), .a_ack(f_a_ack), .a_rdata(f_a_rdata),
      .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_we(b_we), .b_ack(f_b_ack), .b_rdata(f_b_rdata),
      .b_lock(b_lock), .mem_enable(f_mem_enable), .mem_addr(f_mem_addr), .mem_data_in(f_mem_data_in),
      .mem_write_en(f_mem_write_en), .mem_data_out(f_mem_data_out), .busy(f_busy));

   function automatic logic [15:0] init_val(input logic [14:0] ad);
      return {1'b0, ad} ^ 16'hA5C3;
   endfunction

   // Memory model: unwritten words read back as init_val, read data appears the cycle after access.
   always @(posedge clk) begin
      if (mem_enable) begin
         if (mem_write_en) begin
            mem[mem_addr] <= mem_data_in;
            wrt[mem_addr] <= 1'b1;
         end else begin
            mem_data_out <= wrt[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
         end
      end
   end

   // Scoreboard monitor: every ack pops the oldest expectation.
   always @(negedge clk) begin
      if (mon_en && reset) begin
         if (a_ack || b_ack) begin
            exp_t e;
            total++;
            if (a_ack && b_ack) begin
               bad++; $display("FAIL both_ack got a=%b b=%b exp one", a_ack, b_ack);
            end else if (sb.size() == 0) begin
               bad++; $display("FAIL sb_unexpected_ack got a=%b b=%b exp none", a_ack, b_ack);
            end else begin
               e = sb.pop_front();
               if (b_ack !== e.port || (e.chk && ((e.port ? b_rdata : a_rdata) !== e.data))) begin
                  bad++;
                  $display("FAIL sb_ack got port=%b data=%h exp port=%b data=%h",
                           b_ack, b_ack ? b_rdata : a_rdata, e.port, e.data);
               end
            end
         end
         total++;
         if ((!a_ack && a_rdata !== 16'h0000) || (!b_ack && b_rdata !== 16'h0000)) begin
            bad++; $display("FAIL rdata_idle got a=%h b=%h exp 0000", a_rdata, b_rdata);
         end
      end
   end

   task automatic do_reset(input logic ar, input logic br);
      @(negedge clk);
      reset = 1'b0; a_req = ar; b_req = br; a_we = 1'b0; b_we = 1'b0;
      b_lock = 1'b0; mem_ready = 1'b1;
      sb.delete();
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      reset  = 1'b1;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      total++;
      if ({a_ack, b_ack, a_rdata, b_rdata, mem_enable, mem_addr, mem_data_in, mem_write_en, busy} !== 68'd0) begin
         bad++; $display("FAIL reset_outputs got en=%b addr=%h busy=%b exp all 0", mem_enable, mem_addr, busy);
      end
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || mem_enable !== 1'b0) begin
         bad++; $display("FAIL reset_idle got busy=%b en=%b exp 0 0", busy, mem_enable);
      end
   endtask

   task automatic test_init_window;
      mem_ready = 1'b0; a_req = 1'b1; a_addr = 15'h0004; a_we = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if (mem_enable !== 1'b0 || a_ack !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL init_hold got en=%b ack=%b busy=%b exp 0 0 0", mem_enable, a_ack, busy);
         end
      end
      mem_ready = 1'b1;
      sb.push_back('{port: 1'b0, chk: 1'b1, data: init_val(15'h0004)});
      @(negedge clk);
      total++;
      if (mem_enable !== 1'b1 || mem_addr !== 15'h0004 || a_ack !== 1'b0) begin
         bad++; $display("FAIL init_access got en=%b addr=%h ack=%b exp 1 0004 0", mem_enable, mem_addr, a_ack);
      end
      @(negedge clk);
      total++;
      if (a_ack !== 1'b1 || a_rdata !== init_val(15'h0004)) begin
         bad++; $display("FAIL init_ack got ack=%b rdata=%h exp 1 %h", a_ack, a_rdata, init_val(15'h0004));
      end
      a_req = 1'b0;
      @(negedge clk);
      total++;
      if (a_ack !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL init_after got ack=%b busy=%b exp 0 0", a_ack, busy);
      end
   endtask

   task automatic test_b_write_read;
      int  nwe = 0;
      bit  got = 1'b0;
      b_addr = 15'h0100; b_wdata = 16'hBEEF; b_we = 1'b1; b_req = 1'b1;
      sb.push_back('{port: 1'b1, chk: 1'b0, data: 16'h0000});
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (mem_write_en) begin
            nwe++;
            total++;
            if (mem_data_in !== 16'hBEEF || mem_addr !== 15'h0100) begin
               bad++; $display("FAIL b_write_bus got addr=%h data=%h exp 0100 beef", mem_addr, mem_data_in);
            end
         end
         total++;
         if (a_ack !== 1'b0) begin
            bad++; $display("FAIL b_write_a_ack got %b exp 0", a_ack);
         end
         if (b_ack) begin
            got = 1'b1; b_req = 1'b0; b_we = 1'b0;
         end
      end
      total++;
      if (!got || nwe != 1) begin
         bad++; $display("FAIL b_write_done got ack=%b we_cycles=%0d exp 1 1", got, nwe);
      end
      @(negedge clk);
      b_req = 1'b1;
      sb.push_back('{port: 1'b1, chk: 1'b1, data: 16'hBEEF});
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         total++;
         if (a_ack !== 1'b0 || mem_write_en !== 1'b0) begin
            bad++; $display("FAIL b_read_side got a_ack=%b we=%b exp 0 0", a_ack, mem_write_en);
         end
         if (b_ack) begin
            got = 1'b1; b_req = 1'b0;
            total++;
            if (b_rdata !== 16'hBEEF) begin
               bad++; $display("FAIL b_read_data got %h exp beef", b_rdata);
            end
         end
      end
      total++;
      if (!got) begin
         bad++; $display("FAIL b_read_timeout got no ack exp ack");
      end
   endtask

   task automatic test_round_robin;
      int n = 0;
      int c0;
      int tk[4];
      a_addr = 15'h0010; b_addr = 15'h0020;
      do_reset(1'b1, 1'b1);
      c0 = cyc;
      for (int k = 0; k < 4; k++)
         sb.push_back('{port: k[0], chk: 1'b1, data: init_val(k[0] ? 15'h0020 : 15'h0010)});
      for (int i = 0; i < 14 && n < 4; i++) begin
         @(negedge clk);
         if (a_ack || b_ack) begin
            total++;
            if (b_ack !== n[0]) begin
               bad++; $display("FAIL rr_order idx=%0d got b_ack=%b exp %b", n, b_ack, n[0]);
            end
            tk[n] = cyc;
            n++;
            if (n == 4) begin
               a_req = 1'b0; b_req = 1'b0;
            end
         end
      end
      total++;
      if (n != 4) begin
         bad++; $display("FAIL rr_count got %0d exp 4", n);
      end else begin
         total++;
         if (tk[0] - c0 != 2) begin
            bad++; $display("FAIL rr_latency got %0d exp 2", tk[0] - c0);
         end
         for (int k = 1; k < 4; k++) begin
            total++;
            if (tk[k] - tk[k-1] != 2) begin
               bad++; $display("FAIL rr_spacing idx=%0d got %0d exp 2", k, tk[k] - tk[k-1]);
            end
         end
      end
      repeat (3) @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL rr_drain got busy=%b exp 0", busy);
      end
   endtask

   task automatic test_fixed_prio;
      int fn = 0;
      int first_main = -1;
      logic fo[3];
      bit got = 1'b0;
      a_addr = 15'h0010; b_addr = 15'h0020;
      do_reset(1'b1, 1'b0);
      mon_en = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
         @(negedge clk);
         if (f_a_ack) begin
            got = 1'b1; a_req = 1'b0;
         end
      end
      repeat (2) @(negedge clk);
      a_req = 1'b1; b_req = 1'b1;
      for (int i = 0; i < 16 && fn < 3; i++) begin
         @(negedge clk);
         if ((a_ack || b_ack) && first_main < 0) first_main = b_ack ? 1 : 0;
         total++;
         if (f_a_ack && f_b_ack) begin
            bad++; $display("FAIL fp_both_ack got 1 1 exp one");
         end
         if (f_a_ack || f_b_ack) begin
            fo[fn] = f_b_ack;
            fn++;
            if (fn == 3) begin
               a_req = 1'b0; b_req = 1'b0;
            end
         end
      end
      total++;
      if (fn != 3) begin
         bad++; $display("FAIL fp_count got %0d exp 3", fn);
      end else begin
         total++;
         if (fo[0] !== 1'b0 || fo[1] !== 1'b1 || fo[2] !== 1'b0) begin
            bad++; $display("FAIL fp_order got %b%b%b exp 010", fo[0], fo[1], fo[2]);
         end
      end
      total++;
      if (first_main != 1) begin
         bad++; $display("FAIL rr_tiebreak_after_a got %0d exp 1", first_main);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_lock;
      int nb = 0;
      bit got = 1'b0;
      do_reset(1'b0, 1'b0);
      a_addr = 15'h0030; a_req = 1'b1;
      sb.push_back('{port: 1'b0, chk: 1'b1, data: init_val(15'h0030)});
      for (int i = 0; i < 5 && !got; i++) begin
         @(negedge clk);
         got = mem_enable;
      end
      b_lock = 1'b1; b_req = 1'b1; b_we = 1'b1; b_addr = 15'h0200; b_wdata = 16'h1000;
      sb.push_back('{port: 1'b1, chk: 1'b0, data: 16'h0000});
      @(negedge clk);
      total++;
      if (a_ack !== 1'b1) begin
         bad++; $display("FAIL lock_inflight_ack got %b exp 1", a_ack);
      end
      a_addr = 15'h0031;
      for (int i = 0; i < 20 && nb < 3; i++) begin
         @(negedge clk);
         total++;
         if (a_ack !== 1'b0) begin
            bad++; $display("FAIL lock_a_ack got %b exp 0", a_ack);
         end
         if (b_ack) begin
            nb++;
            if (nb < 3) begin
               b_addr = b_addr + 15'h0001; b_wdata = b_wdata + 16'h0001;
               sb.push_back('{port: 1'b1, chk: 1'b0, data: 16'h0000});
            end else begin
               b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0;
               sb.push_back('{port: 1'b0, chk: 1'b1, data: init_val(15'h0031)});
            end
         end
      end
      total++;
      if (nb != 3) begin
         bad++; $display("FAIL lock_b_writes got %0d exp 3", nb);
      end
      got = 1'b0;
      for (int i = 0; i < 3 && !got; i++) begin
         @(negedge clk);
         if (a_ack) begin
            got = 1'b1; a_req = 1'b0;
         end
      end
      total++;
      if (!got) begin
         bad++; $display("FAIL lock_release_ack got none exp ack within 3");
      end
      @(negedge clk);
      b_addr = 15'h0201; b_req = 1'b1;
      sb.push_back('{port: 1'b1, chk: 1'b1, data: 16'h1001});
      got = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
         @(negedge clk);
         if (b_ack) begin
            got = 1'b1; b_req = 1'b0;
         end
      end
      total++;
      if (!got) begin
         bad++; $display("FAIL lock_readback got none exp ack");
      end
   endtask

   task automatic test_reset_mid;
      int n = 0;
      bit got = 1'b0;
      a_addr = 15'h0040; b_addr = 15'h0050; a_we = 1'b0; b_we = 1'b0;
      @(negedge clk);
      a_req = 1'b1;
      for (int i = 0; i < 5 && !got; i++) begin
         @(negedge clk);
         got = mem_enable;
      end
      reset = 1'b0; b_req = 1'b1;
      #1;
      total++;
      if ({a_ack, b_ack, a_rdata, b_rdata, mem_enable, mem_addr, mem_data_in, mem_write_en, busy} !== 68'd0) begin
         bad++; $display("FAIL mid_reset_outputs got en=%b addr=%h busy=%b exp all 0", mem_enable, mem_addr, busy);
      end
      repeat (2) begin
         @(negedge clk);
         total++;
         if (a_ack !== 1'b0 || b_ack !== 1'b0) begin
            bad++; $display("FAIL mid_reset_ack got a=%b b=%b exp 0 0", a_ack, b_ack);
         end
      end
      sb.push_back('{port: 1'b0, chk: 1'b1, data: init_val(15'h0040)});
      sb.push_back('{port: 1'b1, chk: 1'b1, data: init_val(15'h0050)});
      reset = 1'b1;
      for (int i = 0; i < 10 && n < 2; i++) begin
         @(negedge clk);
         if (a_ack || b_ack) begin
            if (n == 0) begin
               total++;
               if (a_ack !== 1'b1) begin
                  bad++; $display("FAIL mid_reset_first got a_ack=%b exp 1", a_ack);
               end
            end
            if (a_ack) a_req = 1'b0;
            if (b_ack) b_req = 1'b0;
            n++;
         end
      end
      total++;
      if (n != 2) begin
         bad++; $display("FAIL mid_reset_count got %0d exp 2", n);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      reset = 1'b0; mem_ready = 1'b0; b_lock = 1'b0;
      a_req = 1'b0; a_we = 1'b0; a_addr = 15'h0000; a_wdata = 16'h0000;
      b_req = 1'b0; b_we = 1'b0; b_addr = 15'h0000; b_wdata = 16'h0000;
      test_reset;
      test_init_window;
      test_b_write_read;
      test_round_robin;
      test_fixed_prio;
      test_lock;
      test_reset_mid;
      total++;
      if (sb.size() != 0) begin
         bad++; $display("FAIL sb_leftover got %0d exp 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/reflet_inst16_arbiter.md
Name: reflet_inst16_arbiter

Overview:
Arbitrates the 16-bit instruction memory between two requesters. Port A is the CPU instruction/data fetch path. Port B is the program loader/debug path, which writes programs into instruction RAM. The block sits between both requesters and the instruction memory, honours the memory's post-reset initialisation window (mem_ready), and sequences each access as a registered single-word transaction with a one-cycle ack.

Parameters:
FIXED_PRIO, 0, 0 = round-robin between A and B; 1 = A always wins simultaneous requests
ADDR_W, 15, word address width
DATA_W, 16, data width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
mem_ready  in  1  instruction memory initialised (inst_ready); no grant while low
a_req  in  1  port A request; hold with a_addr/a_wdata/a_we stable until a_ack
a_addr  in  ADDR_W  port A word address
a_wdata  in  DATA_W  port A write data
a_we  in  1  port A write (1) / read (0)
a_ack  out  1  one-cycle completion pulse for port A
a_rdata  out  DATA_W  read data; equals mem_data_out while a_ack=1, else 0
b_req, b_addr, b_wdata, b_we, b_ack, b_rdata  as port A, for port B
b_lock  in  1  while 1, no new grant to A (loader owns memory); in-flight A access completes
mem_enable  out  1  memory enable, registered
mem_addr  out  ADDR_W  registered address to memory
mem_data_in  out  DATA_W  registered write data
mem_write_en  out  1  registered write strobe
mem_data_out  in  DATA_W  memory read data, valid the cycle after the access cycle
busy  out  1  1 in ACCESS or DONE

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0.
  - last_grant=B, so A wins the first tie in round-robin mode.
  - A reset mid-transaction aborts it with no ack.
- States: IDLE, ACCESS, DONE; granted port is held in an internal register, sel.
- Eligibility:
  - A is eligible when a_req & ~b_lock & mem_ready.
  - B is eligible when b_req & mem_ready.
- Winner selection when both are eligible:
  - FIXED_PRIO=1: A wins.
  - FIXED_PRIO=0: the port not equal to last_grant wins.
  - A single eligible port always wins.
- IDLE: if any port is eligible, latch the winner's addr/wdata/we into the mem_* registers, set mem_enable=1, set sel and last_grant to the winner, go to ACCESS. Otherwise stay in IDLE with mem_enable=0 and mem_write_en=0.
- ACCESS (1 cycle): memory performs the access. Go to DONE. mem_enable and mem_write_en drop to 0 on leaving ACCESS.
- DONE (1 cycle):
  - Pulse the ack of sel. Its rdata = mem_data_out; for writes, rdata is don't-care but still follows the rule.
  - Arbitrate again, excluding the port just acked, because its req is still asserted this cycle.
  - If the other port is eligible, latch it and go to ACCESS (back-to-back). Otherwise go to IDLE.
- Latency and throughput:
  - Request seen in IDLE in cycle N gives ack in cycle N+2.
  - The same port sustains one access per 3 cycles.
  - Alternating ports sustain one access per 2 cycles.
- mem_ready low: no new grants. Requests wait indefinitely. A transaction already granted still completes.
- Requester rules:
  - Dropping req before grant withdraws the request.
  - Dropping req after grant does not cancel the access; ack is still issued.
- b_lock rising while A is in ACCESS: A completes and acks. Subsequent A requests wait until b_lock=0.
- At most one ack is high in any cycle; a_ack and b_ack are never simultaneous.
- Address width: mem_addr is passed through unmodified; no wrap or range check (memory decodes).

Test Plan:
1. Init window: hold mem_ready=0 with a_req=1 at a_addr=0x0004 for 10 cycles → no mem_enable, no a_ack. Raise mem_ready → mem_addr=0x0004 with mem_enable=1 next cycle, a_ack exactly 2 cycles after the sampling edge, a_rdata=mem_data_out.
2. Write then read by B: b_we=1, b_addr=0x0100, b_wdata=0xBEEF → mem_write_en=1 for one cycle, b_ack. Then a read of 0x0100 from B → b_rdata=0xBEEF; a_ack stays 0 throughout.
3. Round-robin contention (FIXED_PRIO=0): a_req and b_req held continuously from reset → grant order A, B, A, B. Acks spaced 2 cycles apart; 4 acks in 8 cycles.
4. Fixed priority (FIXED_PRIO=1), both held → after A's ack, B is served (A's req excluded in DONE). Then A is served again; B is never starved beyond one A access.
5. Lock: b_lock=1 raised during an A ACCESS → that A ack still occurs. Further A requests get no ack while B completes 3 writes; after b_lock=0, A is acked within 3 cycles.
6. Reset mid-operation: assert reset in ACCESS → all outputs 0 immediately, no ack. After release with both req high, A is granted first.
